uart_tx_buffer: RTL and testbench

- Consumes the CPU's byte-output strobe stream (an 8-bit byte plus a one-cycle enable, no backpressure).
- Buffers the bytes in a small FIFO and serialises them as 8N1 UART frames on a single line.
- Sits between the cpu output port and the board TX pin; it is the receiving end of the CPU output interface.
- The CPU cannot be stalled, so overflow drops bytes and raises a sticky flag.

---
 rtl/uart_pkg.sv | 16 +
 rtl/byte_fifo.sv | 60 ++++++
 rtl/uart_tx_buffer.sv | 136 +++++++++++++
 tb/tb_uart_tx_buffer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART framing definitions: transmitter states and 8N1 frame shape.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO of 2**FIFO_AW entries with a combinational head view.
// Latency: write visible at rd_data one cycle after wr_en; count updates on the same edge.
// Backpressure: none; writes when full are ignored unless a read happens in the same cycle.
module byte_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    input  logic               rd_en,
    output logic [7:0]         rd_data,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               wr_ok, rd_ok;

    assign full    = (count_q == (FIFO_AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A read in the same cycle frees the slot, so a full FIFO still accepts that write.
    always_comb begin
        rd_ok    = rd_en && !empty;
        wr_ok    = wr_en && (!full || rd_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        if (wr_ok && !rd_ok)      count_d = count_q + (FIFO_AW+1)'(1);
        else if (!wr_ok && rd_ok) count_d = count_q - (FIFO_AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffers CPU byte strobes and serialises them as 8N1 UART frames on tx.
// Latency: byte strobed into an empty buffer at edge N drives the start bit from edge N+1.
// Backpressure: none; a strobe into a full buffer with no pop is dropped and sets sticky overflow.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         data_in,
    input  logic               data_in_en,
    output logic               tx,
    output logic               busy,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int TW = $clog2(CLK_DIV);

    tx_state_e        state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             overflow_q, overflow_d;

    logic [7:0]       fifo_rd_data;
    logic             fifo_full, fifo_empty;
    logic             pop, timer_wrap;

    byte_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (data_in_en),
        .wr_data (data_in),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign pop        = (state_q == IDLE) && !fifo_empty;
    assign timer_wrap = (timer_q == TW'(CLK_DIV - 1));

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || (fifo_count != '0);

    // tx_d always reflects the level of the state being entered, so tx changes on the transition edge.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        overflow_d = overflow_q | (data_in_en && fifo_full && !pop);

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d = fifo_rd_data;
                    timer_d = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (timer_wrap) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (timer_wrap) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (timer_wrap) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: small instance (CLK_DIV=4, depth 4) plus a default-rate instance (CLK_DIV=434, depth 16).
// An independent line decoder and a timing-level occupancy model provide all expectations.
module tb_uart_tx_buffer;

    localparam int C      = 4;
    localparam int AW     = 2;
    localparam int DEPTH  = 4;
    localparam int CB     = 434;
    localparam int AWB    = 4;
    localparam int DEPTHB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    data_in = '0, data_in_b = '0;
    logic          data_in_en = 1'b0, data_in_en_b = 1'b0;
    logic          tx, busy, overflow;
    logic [AW:0]   fifo_count;
    logic          tx_b, busy_b, overflow_b;
    logic [AWB:0]  fifo_count_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit dec_en = 1'b0;

    logic [7:0] got_q [2][$];
    logic [7:0] exp_q [2][$];
    int         pop_t [2][$];
    int         last_pop [2];
    bit         exp_ovf [2];
    int         glitches [2] = '{0, 0};
    int         start_t [$];
    logic [9:0] frame_bits [$];

    uart_tx_buffer #(.CLK_DIV(C), .FIFO_AW(AW)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_en(data_in_en),
        .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
    );

    uart_tx_buffer #(.CLK_DIV(CB), .FIFO_AW(AWB)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_in_b), .data_in_en(data_in_en_b),
        .tx(tx_b), .busy(busy_b), .overflow(overflow_b), .fifo_count(fifo_count_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation still running at %0t, limit 1500000", $time);
        $fatal(1);
    end

    function automatic logic line(input int inst);
        return (inst == 0) ? tx : tx_b;
    endfunction

    // Samples each bit at its centre; a low level that does not form a valid frame counts as a glitch.
    task automatic decoder(input int inst, input int cd);
        logic [9:0] fr;
        int s;
        forever begin
            @(negedge clk);
            if (dec_en && !rst && line(inst) == 1'b0) begin
                s  = cyc;
                fr = '0;
                for (int j = 0; j < 10 * cd; j++) begin
                    if (j > 0) @(negedge clk);
                    if (j % cd == cd / 2) fr[j / cd] = line(inst);
                end
                if (fr[0] != 1'b0 || fr[9] != 1'b1) glitches[inst]++;
                else got_q[inst].push_back(fr[8:1]);
                if (inst == 0) begin
                    start_t.push_back(s);
                    frame_bits.push_back(fr);
                end
            end
        end
    endtask

    initial begin
        fork
            decoder(0, C);
            decoder(1, CB);
        join_none
    end

    // Occupancy model: each accepted byte leaves the buffer at
    // max(push edge + 1, previous pop + one frame + one idle cycle).
    function automatic void model_push(input int inst, input int t, input int cd, input int depth, input logic [7:0] b);
        int occ, np;
        bit pop_now;
        while (pop_t[inst].size() > 0 && pop_t[inst][0] < t) void'(pop_t[inst].pop_front());
        occ     = pop_t[inst].size();
        pop_now = (occ > 0) && (pop_t[inst][0] == t);
        if (occ >= depth && !pop_now) begin
            exp_ovf[inst] = 1'b1;
            return;
        end
        np = (t + 1 > last_pop[inst] + 10 * cd + 1) ? t + 1 : last_pop[inst] + 10 * cd + 1;
        pop_t[inst].push_back(np);
        last_pop[inst] = np;
        exp_q[inst].push_back(b);
    endfunction

    function automatic int model_count(input int inst, input int t);
        int n = 0;
        foreach (pop_t[inst][k]) if (pop_t[inst][k] > t) n++;
        return n;
    endfunction

    function automatic bit model_busy(input int inst, input int t, input int cd);
        return (model_count(inst, t) > 0) || (t >= last_pop[inst] && t < last_pop[inst] + 10 * cd);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            pop_t[i].delete();
            exp_q[i].delete();
            got_q[i].delete();
            last_pop[i] = -1000000;
            exp_ovf[i]  = 1'b0;
        end
        start_t.delete();
        frame_bits.delete();
    endfunction

    // Drive one cycle of input starting at a negedge; returns at the next negedge (cyc = edge just taken).
    task automatic drive(input bit en, input logic [7:0] b);
        data_in    = b;
        data_in_en = en;
        @(negedge clk);
        if (en && !rst) model_push(0, cyc, C, DEPTH, b);
    endtask

    task automatic drive_b(input bit en, input logic [7:0] b);
        data_in_b    = b;
        data_in_en_b = en;
        @(negedge clk);
        if (en && !rst) model_push(1, cyc, CB, DEPTHB, b);
    endtask

    task automatic test_reset();
        bit stray;
        int t;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h5A + 8'(i));
            checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", tx); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
            checks++; if (fifo_count !== '0) begin failures++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
            checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        end
        drive(1'b0, 8'h00);
        rst = 1'b0;
        model_reset();
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 8'h00);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== '0) stray = 1'b1;
        end
        checks++; if (stray) begin failures++; $display("FAIL reset_no_frame: activity seen=%b want 0", stray); end

        drive(1'b1, 8'h00);
        t = cyc;
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        drive(1'b0, 8'h00);
        while (cyc < t + 1 + C + 2) drive(1'b0, 8'h00);
        checks++; if (tx !== 1'b0) begin failures++; $display("FAIL mid_data_line: got %b want 0", tx); end
        checks++; if (int'(fifo_count) != 2) begin failures++; $display("FAIL mid_data_count: got %0d want 2", fifo_count); end
        rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rst_tx_immediate: got %b want 1", tx); end
        checks++; if (fifo_count !== '0) begin failures++; $display("FAIL rst_count_immediate: got %0d want 0", fifo_count); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        stray = 1'b0;
        for (int i = 0; i < 60; i++) begin
            drive(1'b0, 8'h00);
            if (tx !== 1'b1 || fifo_count !== '0 || busy !== 1'b0) stray = 1'b1;
        end
        checks++; if (stray) begin failures++; $display("FAIL post_abort_idle: activity seen=%b want 0", stray); end
        dec_en = 1'b1;
    endtask

    task automatic test_single();
        int t, n;
        logic [9:0] ev;
        int eb [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        model_reset();
        for (int i = 0; i < 10; i++) ev[i] = eb[i][0];
        drive(1'b1, 8'hA5);
        t = cyc;
        drive(1'b0, 8'h00);
        n = 0;
        while (busy && n < 500) begin @(negedge clk); n++; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_timeout: busy=%b want 0", busy); end
        checks++; if (cyc != t + 10 * C + 1) begin failures++; $display("FAIL single_busy_drop: got edge +%0d want +%0d", cyc - t, 10 * C + 1); end
        checks++;
        if (start_t.size() != 1 || got_q[0].size() != 1) begin
            failures++; $display("FAIL single_frames: got %0d frames want 1", start_t.size());
        end else begin
            if (start_t[0] != t + 1) begin failures++; $display("FAIL single_latency: start at +%0d want +1", start_t[0] - t); end
            checks++; if (frame_bits[0] !== ev) begin failures++; $display("FAIL single_bits: got %b want %b", frame_bits[0], ev); end
            checks++; if (got_q[0][0] !== 8'hA5) begin failures++; $display("FAIL single_byte: got %h want a5", got_q[0][0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat [3] = '{8'h01, 8'h80, 8'hFF};
        int peak, n;
        model_reset();
        peak = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pat[i]);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        drive(1'b0, 8'h00);
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk); n++;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_timeout: busy=%b want 0", busy); end
        checks++; if (peak != 2) begin failures++; $display("FAIL b2b_peak: got %0d want 2", peak); end
        checks++;
        if (got_q[0].size() != 3 || start_t.size() != 3) begin
            failures++; $display("FAIL b2b_frames: got %0d want 3", got_q[0].size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (i > 0) checks++;
                if (got_q[0][i] !== pat[i]) begin failures++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[0][i], pat[i]); end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (start_t[i] - start_t[i-1] != 10 * C + 1) begin
                    failures++; $display("FAIL b2b_period%0d: got %0d want %0d", i, start_t[i] - start_t[i-1], 10 * C + 1);
                end
            end
        end
    endtask

    task automatic test_overflow();
        bit ovf_seen [6];
        int n;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'h30 + 8'(i));
            ovf_seen[i] = overflow;
        end
        drive(1'b0, 8'h00);
        checks++; if (ovf_seen[4] !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b want 0", ovf_seen[4]); end
        checks++; if (ovf_seen[5] !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", ovf_seen[5]); end
        n = 0;
        while (busy && n < 2000) begin @(negedge clk); n++; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovf_timeout: busy=%b want 0", busy); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        checks++;
        if (got_q[0].size() != 5) begin
            failures++; $display("FAIL ovf_frames: got %0d want 5", got_q[0].size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (i > 0) checks++;
                if (got_q[0][i] !== 8'h30 + 8'(i)) begin failures++; $display("FAIL ovf_byte%0d: got %h want %h", i, got_q[0][i], 8'h30 + 8'(i)); end
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared: got %b want 0", overflow); end
    endtask

    task automatic test_full_pop();
        logic [7:0] want [6] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h5C};
        int t, n;
        model_reset();
        drive(1'b1, want[0]);
        t = cyc;
        for (int i = 1; i < 5; i++) drive(1'b1, want[i]);
        drive(1'b0, 8'h00);
        while (cyc < t + 10 * C + 1) drive(1'b0, 8'h00);
        checks++; if (int'(fifo_count) != 4) begin failures++; $display("FAIL fullpop_before: got %0d want 4", fifo_count); end
        drive(1'b1, want[5]);
        checks++; if (int'(fifo_count) != 4) begin failures++; $display("FAIL fullpop_count: got %0d want 4", fifo_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
        drive(1'b0, 8'h00);
        n = 0;
        while (busy && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (got_q[0].size() != 6) begin
            failures++; $display("FAIL fullpop_frames: got %0d want 6", got_q[0].size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_q[0][i] !== want[i]) begin failures++; $display("FAIL fullpop_byte%0d: got %h want %h", i, got_q[0][i], want[i]); end
            end
        end
    endtask

    task automatic test_random();
        int g, n;
        model_reset();
        for (int i = 0; i < 150; i++) begin
            drive(1'b1, 8'($urandom));
            checks++;
            if (int'(fifo_count) != model_count(0, cyc)) begin
                failures++; $display("FAIL rand_count%0d: got %0d want %0d", i, fifo_count, model_count(0, cyc));
            end
            checks++;
            if (busy !== model_busy(0, cyc, C)) begin
                failures++; $display("FAIL rand_busy%0d: got %b want %b", i, busy, model_busy(0, cyc, C));
            end
            g = $urandom_range(0, 90);
            for (int k = 0; k < g; k++) drive(1'b0, 8'h00);
        end
        drive(1'b0, 8'h00);
        n = 0;
        while (busy && n < 10000) begin @(negedge clk); n++; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rand_timeout: busy=%b want 0", busy); end
        checks++; if (overflow !== exp_ovf[0]) begin failures++; $display("FAIL rand_ovf: got %b want %b", overflow, exp_ovf[0]); end
        checks++; if (glitches[0] != 0) begin failures++; $display("FAIL rand_glitch: got %0d want 0", glitches[0]); end
        checks++;
        if (got_q[0].size() != exp_q[0].size()) begin
            failures++; $display("FAIL rand_frames: got %0d want %0d", got_q[0].size(), exp_q[0].size());
        end else begin
            foreach (exp_q[0][i]) begin
                checks++;
                if (got_q[0][i] !== exp_q[0][i]) begin failures++; $display("FAIL rand_byte%0d: got %h want %h", i, got_q[0][i], exp_q[0][i]); end
            end
        end
    endtask

    task automatic test_default_params();
        int g, n;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            drive_b(1'b1, 8'($urandom));
            checks++;
            if (int'(fifo_count_b) != model_count(1, cyc)) begin
                failures++; $display("FAIL div434_count%0d: got %0d want %0d", i, fifo_count_b, model_count(1, cyc));
            end
            g = $urandom_range(0, 800);
            for (int k = 0; k < g; k++) drive_b(1'b0, 8'h00);
        end
        drive_b(1'b0, 8'h00);
        n = 0;
        while (busy_b && n < 60000) begin @(negedge clk); n++; end
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL div434_timeout: busy=%b want 0", busy_b); end
        checks++; if (overflow_b !== exp_ovf[1]) begin failures++; $display("FAIL div434_ovf: got %b want %b", overflow_b, exp_ovf[1]); end
        checks++; if (glitches[1] != 0) begin failures++; $display("FAIL div434_glitch: got %0d want 0", glitches[1]); end
        checks++;
        if (got_q[1].size() != exp_q[1].size()) begin
            failures++; $display("FAIL div434_frames: got %0d want %0d", got_q[1].size(), exp_q[1].size());
        end else begin
            foreach (exp_q[1][i]) begin
                checks++;
                if (got_q[1][i] !== exp_q[1][i]) begin failures++; $display("FAIL div434_byte%0d: got %h want %h", i, got_q[1][i], exp_q[1][i]); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_random();
        test_default_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
